// File: rtl/instr_prefetch_queue_pkg.sv
// Shared constants and types for the CPU10 instruction prefetch queue.
package instr_prefetch_queue_pkg;

    localparam int INSTR_W          = 10;
    localparam int PC_W             = 10;
    localparam int DEFAULT_RESET_PC = 0;
    localparam int OCC_W            = 5;

    // One queued instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// ROM fetch port plus decode-side handshake for the prefetch queue.
interface instr_prefetch_queue_if
    import instr_prefetch_queue_pkg::*;
#(
    parameter int DATA_W = INSTR_W,
    parameter int ADDR_W = PC_W
) ();

    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic [OCC_W-1:0]  occupancy;
    logic              halted;

    // Prefetch queue side.
    modport master (
        output rom_req, rom_addr, instr_valid, instr, instr_pc, occupancy, halted,
        input  rom_data, redirect, redirect_pc, halt, instr_ready
    );

    // ROM / decode side.
    modport slave (
        input  rom_req, rom_addr, instr_valid, instr, instr_pc, occupancy, halted,
        output rom_data, redirect, redirect_pc, halt, instr_ready
    );

endinterface

// File: rtl/instr_prefetch_queue_sync_fifo.sv
// Small synchronous FIFO with flush and first-word fall-through head.
// Head data reads as zero while empty so the decode side never sees stale words.
module instr_prefetch_queue_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;
    assign do_pop     = pop && head_valid && !flush;
    // Push at full is only accepted together with a pop.
    assign do_push    = push && !flush && ((count < CNT_W'(DEPTH)) || do_pop);

    // Storage write; data needs no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Pointer and count bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)
                rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch stage: sequential ROM reads with one-cycle fixed latency, queued with
// their PCs and presented to decode. Branch redirects flush; halt is sticky.
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int DATA_W   = INSTR_W,
    parameter int ADDR_W   = PC_W,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instr_prefetch_queue_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic              pending;
    logic [ADDR_W-1:0] pending_pc;
    logic              halted;
    logic              pop;
    logic              issue;
    logic              head_valid;
    logic [CNT_W-1:0]  count;
    logic [5:0]        inflight;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    assign pop = head_valid && bus.instr_ready;

    // Credit: queued + in-flight words after this cycle's pop must leave room
    // for the word this issue will return, so a push can never overflow.
    assign inflight = 6'(count) + 6'(pending) - 6'(pop);
    assign issue    = rst_n && !halted && !bus.halt && !bus.redirect
                    && (inflight < 6'(DEPTH));

    assign push_entry.instr = bus.rom_data;
    assign push_entry.pc    = pending_pc;

    instr_prefetch_queue_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (pending && !bus.redirect),
        .push_data  (push_entry),
        .pop        (pop),
        .flush      (bus.redirect),
        .head_valid (head_valid),
        .head_data  (head_entry),
        .count      (count)
    );

    // Fetch PC, in-flight tracking and sticky halt; redirect outranks issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc   <= ADDR_W'(RESET_PC);
            pending    <= 1'b0;
            pending_pc <= '0;
            halted     <= 1'b0;
        end else begin
            if (bus.halt)
                halted <= 1'b1;
            if (bus.redirect) begin
                pending <= 1'b0;
                // Once halted the PC is frozen; the flush still happens.
                if (!halted)
                    fetch_pc <= bus.redirect_pc;
            end else begin
                pending <= issue;
                if (issue) begin
                    pending_pc <= fetch_pc;
                    fetch_pc   <= fetch_pc + 1'b1;
                end
            end
        end
    end

    assign bus.rom_req     = issue;
    assign bus.rom_addr    = fetch_pc;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_entry.instr;
    assign bus.instr_pc    = head_entry.pc;
    assign bus.occupancy   = OCC_W'(count);
    assign bus.halted      = halted;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: a vector table for fill/stall/drain,
// then hand sequences for redirect, PC wrap, halt and mid-run reset.
module tb_instr_prefetch_queue;
    import instr_prefetch_queue_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    instr_prefetch_queue_if #(.DATA_W(10), .ADDR_W(10)) bus ();

    instr_prefetch_queue #(.DATA_W(10), .ADDR_W(10), .DEPTH(4), .RESET_PC(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] rom_word(input logic [9:0] a);
        return a ^ 10'h2A5;
    endfunction

    // ROM model: fixed one-cycle read latency.
    always_ff @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);

    typedef struct {
        logic ready;
        logic exp_req;
        int   exp_addr;
        logic exp_valid;
        int   exp_pc;
        int   exp_occ;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check outputs for the current cycle, then advance one clock.
    task automatic step_chk(input string tag, input logic req, input int addr,
                            input logic v, input int pc, input int occ);
        #1;
        chk({tag, ".rom_req"},     int'(bus.rom_req),     int'(req));
        chk({tag, ".rom_addr"},    int'(bus.rom_addr),    addr);
        chk({tag, ".instr_valid"}, int'(bus.instr_valid), int'(v));
        chk({tag, ".occupancy"},   int'(bus.occupancy),   occ);
        if (v) begin
            chk({tag, ".instr_pc"}, int'(bus.instr_pc), pc);
            chk({tag, ".instr"},    int'(bus.instr),    int'(rom_word(10'(pc))));
        end
        cyc();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;
        cyc();
        cyc();
        chk("rst.rom_req",     int'(bus.rom_req),     0);
        chk("rst.rom_addr",    int'(bus.rom_addr),    0);
        chk("rst.instr_valid", int'(bus.instr_valid), 0);
        chk("rst.instr",       int'(bus.instr),       0);
        chk("rst.instr_pc",    int'(bus.instr_pc),    0);
        chk("rst.occupancy",   int'(bus.occupancy),   0);
        chk("rst.halted",      int'(bus.halted),      0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;

        // cycle: ready, req, addr, valid, pc, occ
        vecs.push_back('{1'b1, 1'b1, 0,  1'b0, 0, 0});
        vecs.push_back('{1'b1, 1'b1, 1,  1'b0, 0, 0});
        vecs.push_back('{1'b1, 1'b1, 2,  1'b1, 0, 1});
        vecs.push_back('{1'b1, 1'b1, 3,  1'b1, 1, 1});
        vecs.push_back('{1'b1, 1'b1, 4,  1'b1, 2, 1});
        vecs.push_back('{1'b1, 1'b1, 5,  1'b1, 3, 1});
        vecs.push_back('{1'b0, 1'b1, 6,  1'b1, 4, 1});
        vecs.push_back('{1'b0, 1'b1, 7,  1'b1, 4, 2});
        vecs.push_back('{1'b0, 1'b0, 8,  1'b1, 4, 3});
        for (int i = 0; i < 7; i++)
            vecs.push_back('{1'b0, 1'b0, 8, 1'b1, 4, 4});
        vecs.push_back('{1'b1, 1'b1, 8,  1'b1, 4, 4});
        vecs.push_back('{1'b1, 1'b1, 9,  1'b1, 5, 3});
        vecs.push_back('{1'b1, 1'b1, 10, 1'b1, 6, 3});
        vecs.push_back('{1'b1, 1'b1, 11, 1'b1, 7, 3});
        vecs.push_back('{1'b1, 1'b1, 12, 1'b1, 8, 3});
        vecs.push_back('{1'b1, 1'b1, 13, 1'b1, 9, 3});

        // Streaming, 10-cycle stall with saturation, then in-order drain.
        reset_dut();
        foreach (vecs[i]) begin
            bus.instr_ready = vecs[i].ready;
            step_chk($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                     vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_occ);
        end

        // Redirect with 3 queued + 1 pending, then redirect across the PC wrap.
        reset_dut();
        step_chk("rd0", 1'b1, 0, 1'b0, 0, 0);
        step_chk("rd1", 1'b1, 1, 1'b0, 0, 0);
        step_chk("rd2", 1'b1, 2, 1'b1, 0, 1);
        step_chk("rd3", 1'b1, 3, 1'b1, 0, 2);
        bus.redirect = 1'b1;
        bus.redirect_pc = 10'h050;
        step_chk("rd4", 1'b0, 4, 1'b1, 0, 3);
        bus.redirect = 1'b0;
        bus.instr_ready = 1'b1;
        step_chk("rd5", 1'b1, 'h050, 1'b0, 0, 0);
        step_chk("rd6", 1'b1, 'h051, 1'b0, 0, 0);
        step_chk("rd7", 1'b1, 'h052, 1'b1, 'h050, 1);
        bus.redirect = 1'b1;
        bus.redirect_pc = 10'h3FE;
        step_chk("wr0", 1'b0, 'h053, 1'b1, 'h051, 1);
        bus.redirect = 1'b0;
        step_chk("wr1", 1'b1, 'h3FE, 1'b0, 0, 0);
        step_chk("wr2", 1'b1, 'h3FF, 1'b0, 0, 0);
        step_chk("wr3", 1'b1, 'h000, 1'b1, 'h3FE, 1);
        step_chk("wr4", 1'b1, 'h001, 1'b1, 'h3FF, 1);
        step_chk("wr5", 1'b1, 'h002, 1'b1, 'h000, 1);

        // Halt with PC 7 in flight: it is still delivered, then nothing more.
        reset_dut();
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 8; k++)
            step_chk($sformatf("h%0d", k), 1'b1, k, (k >= 2), k - 2, (k >= 2) ? 1 : 0);
        bus.halt = 1'b1;
        step_chk("h8", 1'b0, 8, 1'b1, 6, 1);
        bus.halt = 1'b0;
        #1 chk("h9.halted", int'(bus.halted), 1);
        step_chk("h9", 1'b0, 8, 1'b1, 7, 1);
        step_chk("h10", 1'b0, 8, 1'b0, 0, 0);
        bus.redirect = 1'b1;
        bus.redirect_pc = 10'h100;
        step_chk("h11", 1'b0, 8, 1'b0, 0, 0);
        bus.redirect = 1'b0;
        step_chk("h12", 1'b0, 8, 1'b0, 0, 0);
        step_chk("h13", 1'b0, 8, 1'b0, 0, 0);
        #1 chk("h13.halted", int'(bus.halted), 1);

        // Reset for one edge with the queue full and halted set.
        reset_dut();
        step_chk("r0", 1'b1, 0, 1'b0, 0, 0);
        step_chk("r1", 1'b1, 1, 1'b0, 0, 0);
        step_chk("r2", 1'b1, 2, 1'b1, 0, 1);
        step_chk("r3", 1'b1, 3, 1'b1, 0, 2);
        step_chk("r4", 1'b0, 4, 1'b1, 0, 3);
        bus.halt = 1'b1;
        step_chk("r5", 1'b0, 4, 1'b1, 0, 4);
        bus.halt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("r6.rom_req_in_reset", int'(bus.rom_req), 0);
        chk("r6.halted", int'(bus.halted), 1);
        chk("r6.occupancy", int'(bus.occupancy), 4);
        cyc();
        rst_n = 1'b1;
        #1 chk("r7.halted", int'(bus.halted), 0);
        step_chk("r7", 1'b1, 0, 1'b0, 0, 0);
        bus.instr_ready = 1'b1;
        step_chk("r8", 1'b1, 1, 1'b0, 0, 0);
        step_chk("r9", 1'b1, 2, 1'b1, 0, 1);
        step_chk("r10", 1'b1, 3, 1'b1, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
